// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer with a 2-bit saturating counter per entry.
// Combinational lookup from IF, one-cycle registered training, saturating perf counters.
module bpu_btb #(
   parameter int unsigned ENTRIES      = 16,
   parameter int unsigned CNT_W        = 32,
   parameter logic [1:0]  CTR_ALLOC_BR = 2'b10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      if_pc,
   output logic             pred_taken,
   output logic [31:0]      pred_npc,
   input  logic             upd_valid,
   input  logic [31:0]      upd_pc,
   input  logic             upd_is_jmp,
   input  logic             upd_taken,
   input  logic [31:0]      upd_target,
   input  logic             upd_mispred,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] mis_cnt
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = 30 - IDX_W;

   logic [ENTRIES-1:0] valid_q;
   logic [ENTRIES-1:0] jmp_q;
   logic [1:0]         ctr_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];

   logic [IDX_W-1:0] lk_idx;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] lk_tag;
   logic [TAG_W-1:0] upd_tag;
   logic             hit;
   logic             upd_hit;
   logic             wr_en;
   logic [1:0]       ctr_d;
   logic [31:0]      target_d;
   logic             jmp_d;

   logic [CNT_W-1:0] hit_cnt_q;
   logic [CNT_W-1:0] mis_cnt_q;

   logic unused_pc_bits;
   assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

   assign lk_idx  = if_pc[IDX_W+1:2];
   assign lk_tag  = if_pc[31:IDX_W+2];
   assign upd_idx = upd_pc[IDX_W+1:2];
   assign upd_tag = upd_pc[31:IDX_W+2];

   always_comb begin
      hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_taken = hit && (jmp_q[lk_idx] || ctr_q[lk_idx][1]);
      pred_npc   = pred_taken ? target_q[lk_idx] : if_pc + 32'd4;
   end

   always_comb begin
      wr_en    = 1'b0;
      ctr_d    = ctr_q[upd_idx];
      target_d = target_q[upd_idx];
      jmp_d    = jmp_q[upd_idx];
      upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
      if (upd_valid) begin
         if (upd_hit) begin
            wr_en = 1'b1;
            jmp_d = upd_is_jmp;
            if (upd_taken) begin
               target_d = upd_target;
               // Jumps predict taken regardless, so a taken jump leaves ctr alone.
               if (!upd_is_jmp && ctr_q[upd_idx] != 2'b11) begin
                  ctr_d = ctr_q[upd_idx] + 2'd1;
               end
            end else if (ctr_q[upd_idx] != 2'b00) begin
               ctr_d = ctr_q[upd_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            wr_en    = 1'b1;
            target_d = upd_target;
            jmp_d    = upd_is_jmp;
            ctr_d    = upd_is_jmp ? 2'b11 : CTR_ALLOC_BR;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < int'(ENTRIES); i++) begin
            ctr_q[i] <= 2'b01;
         end
      end else if (wr_en) begin
         valid_q[upd_idx] <= 1'b1;
         ctr_q[upd_idx]   <= ctr_d;
      end
   end

   // Payload needs no reset: it is only observed through a set valid bit.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         tag_q[upd_idx]    <= upd_tag;
         target_q[upd_idx] <= target_d;
         jmp_q[upd_idx]    <= jmp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q <= '0;
         mis_cnt_q <= '0;
      end else begin
         if (hit && hit_cnt_q != '1) begin
            hit_cnt_q <= hit_cnt_q + 1'b1;
         end
         if (upd_valid && upd_mispred && mis_cnt_q != '1) begin
            mis_cnt_q <= mis_cnt_q + 1'b1;
         end
      end
   end

   assign hit_cnt = hit_cnt_q;
   assign mis_cnt = mis_cnt_q;

endmodule
